pipeline_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage ARMv8 pipeline.
- Owns stall, flush and freeze decisions for PC, IF/ID, ID/EX and EX/MEM: load-use stalls, taken-branch flushes, multi-cycle data-memory waits with timeout, and orderly halt/drain.
- State updates on the rising edge of clock, so control outputs are settled before the pipeline registers latch on the falling edge.

---
 rtl/pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: load-use, taken branch, data-memory wait
// with timeout, and halt/drain. Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       MemReadEX,
    input  logic [4:0] RdEX,
    input  logic [4:0] RnID,
    input  logic [4:0] RmID,
    input  logic       usesRmID,
    input  logic       BranchTakenMEM,
    input  logic       MemAccessMEM,
    input  logic       memReady,
    input  logic       HaltID,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       IDEXBubble,
    output logic       EXMEMFlush,
    output logic       PipeFreeze,
    output logic       PCSrcSel,
    output logic       halted,
    output logic       errTimeout,
    output logic [1:0] ctrlState
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] flushEvents,
    output logic [31:0] memWaitCycles
`endif
);

    localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       waitCnt_q, waitCnt_d;
    logic [DCW-1:0]   drainCnt_q, drainCnt_d;
    logic             errTimeout_q, errTimeout_d;
    logic             halted_q, halted_d;

    logic mem_stall;
    logic load_use;
    logic run_eval;
    logic ev_branch;
    logic ev_loaduse;

    assign mem_stall = MemAccessMEM && !memReady;
    assign load_use  = MemReadEX && (RdEX != 5'd31) &&
                       ((RdEX == RnID) || (usesRmID && (RdEX == RmID)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            waitCnt_q    <= '0;
            drainCnt_q   <= '0;
            errTimeout_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            drainCnt_q   <= drainCnt_d;
            errTimeout_q <= errTimeout_d;
            halted_q     <= halted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        drainCnt_d   = drainCnt_q;
        errTimeout_d = errTimeout_q;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IFIDFlush    = 1'b0;
        IDEXBubble   = 1'b0;
        EXMEMFlush   = 1'b0;
        PipeFreeze   = 1'b0;
        PCSrcSel     = 1'b0;
        run_eval     = 1'b0;
        ev_branch    = 1'b0;
        ev_loaduse   = 1'b0;

        unique case (state_q)
            RUN: run_eval = 1'b1;
            MEM_WAIT: begin
                if (memReady) begin
                    // The completing cycle is evaluated as a RUN cycle, including its transitions
                    state_d   = RUN;
                    waitCnt_d = '0;
                    run_eval  = 1'b1;
                end else begin
                    PipeFreeze = 1'b1;
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    if (waitCnt_q == 8'(MEM_TIMEOUT)) begin
                        state_d      = HALT;
                        errTimeout_d = 1'b1;
                    end else if (waitCnt_q != '1) begin
                        waitCnt_d = waitCnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
                if (mem_stall) begin
                    PipeFreeze = 1'b1;
                end else if (32'(drainCnt_q) + 32'd1 >= 32'(DRAIN_CYCLES)) begin
                    state_d = HALT;
                end else begin
                    drainCnt_d = drainCnt_q + DCW'(1);
                end
            end
            HALT: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
                EXMEMFlush = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (run_eval) begin
            if (mem_stall) begin
                PipeFreeze = 1'b1;
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                state_d    = MEM_WAIT;
                waitCnt_d  = 8'd1;
            end else if (BranchTakenMEM) begin
                ev_branch  = 1'b1;
                PCSrcSel   = 1'b1;
                IFIDFlush  = 1'b1;
                IDEXBubble = 1'b1;
                EXMEMFlush = 1'b1;
                PCWrite    = 1'b1;
            end else if (load_use) begin
                ev_loaduse = 1'b1;
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
            end else if (HaltID) begin
                PCWrite    = 1'b0;
                IFIDFlush  = 1'b1;
                state_d    = DRAIN;
                drainCnt_d = '0;
            end
        end

        // Hold outputs at their idle RUN values for as long as reset is asserted
        if (reset) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b0;
            IDEXBubble = 1'b0;
            EXMEMFlush = 1'b0;
            PipeFreeze = 1'b0;
            PCSrcSel   = 1'b0;
        end
    end

    assign halted_d   = halted_q || (state_d == HALT);
    assign halted     = halted_q;
    assign errTimeout = errTimeout_q;
    assign ctrlState  = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles_q, flushEvents_q, memWaitCycles_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCycles_q   <= '0;
            flushEvents_q   <= '0;
            memWaitCycles_q <= '0;
        end else begin
            if (ev_loaduse && (stallCycles_q != '1))
                stallCycles_q <= stallCycles_q + 32'd1;
            if (ev_branch && (flushEvents_q != '1))
                flushEvents_q <= flushEvents_q + 32'd1;
            if ((state_q == MEM_WAIT) && (memWaitCycles_q != '1))
                memWaitCycles_q <= memWaitCycles_q + 32'd1;
        end
    end

    assign stallCycles   = stallCycles_q;
    assign flushEvents   = flushEvents_q;
    assign memWaitCycles = memWaitCycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int MT = 4;
    localparam int DC = 3;

    typedef struct {
        logic       MemReadEX;
        logic [4:0] RdEX;
        logic [4:0] RnID;
        logic [4:0] RmID;
        logic       usesRmID;
        logic       BranchTakenMEM;
        logic       MemAccessMEM;
        logic       memReady;
        logic       HaltID;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp_o;   // {PCWrite,IFIDWrite,IFIDFlush,IDEXBubble,EXMEMFlush,PipeFreeze,PCSrcSel}
        logic [1:0] exp_st;  // state after the edge
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       MemReadEX = 1'b0, usesRmID = 1'b0, BranchTakenMEM = 1'b0;
    logic       MemAccessMEM = 1'b0, memReady = 1'b0, HaltID = 1'b0;
    logic [4:0] RdEX = '0, RnID = '0, RmID = '0;
    logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, EXMEMFlush, PipeFreeze, PCSrcSel;
    logic       halted, errTimeout;
    logic [1:0] ctrlState;
    logic [6:0] act_o;

    int n_checks = 0;
    int n_errors = 0;

    int m_state, m_wait, m_drain;
    bit m_err;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC)) dut (
        .clock(clock), .reset(reset),
        .MemReadEX(MemReadEX), .RdEX(RdEX), .RnID(RnID), .RmID(RmID), .usesRmID(usesRmID),
        .BranchTakenMEM(BranchTakenMEM), .MemAccessMEM(MemAccessMEM), .memReady(memReady),
        .HaltID(HaltID),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
        .EXMEMFlush(EXMEMFlush), .PipeFreeze(PipeFreeze), .PCSrcSel(PCSrcSel),
        .halted(halted), .errTimeout(errTimeout), .ctrlState(ctrlState)
    );

    assign act_o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, EXMEMFlush, PipeFreeze, PCSrcSel};

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk_in(bit mr, int rd, int rn, int rm, bit um, bit br, bit ma, bit rdy, bit h);
        in_t i;
        i.MemReadEX = mr; i.RdEX = 5'(rd); i.RnID = 5'(rn); i.RmID = 5'(rm); i.usesRmID = um;
        i.BranchTakenMEM = br; i.MemAccessMEM = ma; i.memReady = rdy; i.HaltID = h;
        return i;
    endfunction

    function automatic vec_t mk_vec(in_t i, logic [6:0] eo, int es);
        vec_t v;
        v.in = i; v.exp_o = eo; v.exp_st = 2'(es);
        return v;
    endfunction

    task automatic drive(input in_t i);
        MemReadEX = i.MemReadEX; RdEX = i.RdEX; RnID = i.RnID; RmID = i.RmID; usesRmID = i.usesRmID;
        BranchTakenMEM = i.BranchTakenMEM; MemAccessMEM = i.MemAccessMEM; memReady = i.memReady;
        HaltID = i.HaltID;
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic bit hazard(in_t i);
        return i.MemReadEX && (i.RdEX != 5'd31) &&
               ((i.RdEX == i.RnID) || (i.usesRmID && (i.RdEX == i.RmID)));
    endfunction

    function automatic logic [6:0] run_outs(in_t i);
        if (i.MemAccessMEM && !i.memReady) return 7'b0000010;
        if (i.BranchTakenMEM)              return 7'b1111101;
        if (hazard(i))                     return 7'b0001000;
        if (i.HaltID)                      return 7'b0110000;
        return 7'b1100000;
    endfunction

    function automatic logic [6:0] exp_outs(in_t i);
        case (m_state)
            0:       return run_outs(i);
            1:       return i.memReady ? run_outs(i) : 7'b0000010;
            2:       return (i.MemAccessMEM && !i.memReady) ? 7'b0001010 : 7'b0001000;
            default: return 7'b0001100;
        endcase
    endfunction

    task automatic run_next(input in_t i);
        if (i.MemAccessMEM && !i.memReady) begin
            m_state = 1; m_wait = 1;
        end else if (!i.BranchTakenMEM && !hazard(i) && i.HaltID) begin
            m_state = 2; m_drain = 0;
        end
    endtask

    task automatic model_step(input in_t i);
        case (m_state)
            0: run_next(i);
            1: begin
                if (i.memReady) begin
                    m_state = 0; m_wait = 0;
                    run_next(i);
                end else if (m_wait == MT) begin
                    m_state = 3; m_err = 1'b1;
                end else begin
                    m_wait++;
                end
            end
            2: begin
                if (!(i.MemAccessMEM && !i.memReady)) begin
                    m_drain++;
                    if (m_drain >= DC) m_state = 3;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_drain = 0; m_err = 1'b0;
    endtask

    task automatic check_state();
        check("ctrlState", 32'(ctrlState), 32'(m_state));
        check("halted", 32'(halted), 32'(m_state == 3));
        check("errTimeout", 32'(errTimeout), 32'(m_err));
    endtask

    task automatic cycle(input in_t i);
        @(negedge clock);
        check_state();
        drive(i);
        #1;
        check("outs", 32'(act_o), 32'(exp_outs(i)));
        model_step(i);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0));
        #1;
        check("reset outs", 32'(act_o), 32'(7'b1100000));
        check("reset st", 32'({errTimeout, halted, ctrlState}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Asynchronous reset mid-cycle with the current inputs still applied
    task automatic mid_reset(input string tag);
        @(negedge clock);
        check_state();
        #2 reset = 1'b1;
        #1;
        check({tag, " rst ctrlState"}, 32'(ctrlState), 32'd0);
        check({tag, " rst PCWrite"}, 32'(PCWrite), 32'd1);
        check({tag, " rst errTimeout"}, 32'(errTimeout), 32'd0);
        check({tag, " rst halted"}, 32'(halted), 32'd0);
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic int pick_reg();
        int r;
        r = int'($urandom_range(0, 3));
        return (r == 3) ? 31 : r;
    endfunction

    function automatic in_t rand_in(int bias);
        return mk_in($urandom_range(0, 1) == 1, pick_reg(), pick_reg(), pick_reg(),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)) < bias,
                     $urandom_range(0, 19) == 0);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        in_t  idle, stall, ready;
        int   bias;

        idle  = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        stall = mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        ready = mk_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        model_reset();

        vecs[0]  = mk_vec(idle,                                 7'b1100000, 0);
        vecs[1]  = mk_vec(mk_in(1, 5, 5, 0, 0, 0, 0, 1, 0),     7'b0001000, 0);
        vecs[2]  = mk_vec(mk_in(1, 31, 31, 31, 1, 0, 0, 1, 0),  7'b1100000, 0);
        vecs[3]  = mk_vec(mk_in(1, 7, 3, 7, 1, 0, 0, 1, 0),     7'b0001000, 0);
        vecs[4]  = mk_vec(mk_in(1, 7, 3, 7, 0, 0, 0, 1, 0),     7'b1100000, 0);
        vecs[5]  = mk_vec(mk_in(0, 5, 5, 5, 1, 0, 0, 1, 0),     7'b1100000, 0);
        vecs[6]  = mk_vec(mk_in(0, 0, 1, 2, 0, 1, 0, 1, 1),     7'b1111101, 0);
        vecs[7]  = mk_vec(mk_in(1, 4, 4, 0, 0, 1, 0, 1, 0),     7'b1111101, 0);
        vecs[8]  = mk_vec(mk_in(1, 4, 4, 0, 0, 0, 0, 1, 1),     7'b0001000, 0);
        vecs[9]  = mk_vec(mk_in(0, 0, 1, 2, 0, 0, 0, 1, 1),     7'b0110000, 2);
        vecs[10] = mk_vec(stall,                                7'b0000010, 1);
        vecs[11] = mk_vec(mk_in(1, 4, 4, 0, 0, 1, 1, 0, 1),     7'b0000010, 1);
        vecs[12] = mk_vec(ready,                                7'b1100000, 0);

        for (int k = 0; k < 13; k++) begin
            do_reset();
            @(negedge clock);
            drive(vecs[k].in);
            #1;
            check($sformatf("vec%0d outs", k), 32'(act_o), 32'(vecs[k].exp_o));
            @(posedge clock);
            #1;
            check($sformatf("vec%0d state", k), 32'(ctrlState), 32'(vecs[k].exp_st));
        end

        // load-use lasts exactly one cycle
        do_reset();
        cycle(mk_in(1, 5, 5, 0, 0, 0, 0, 1, 0));
        cycle(idle);

        // memory wait: three low cycles, ready on the fourth
        do_reset();
        repeat (3) cycle(stall);
        cycle(ready);
        @(negedge clock);
        check("memwait back to RUN", 32'(ctrlState), 32'd0);

        // timeout and sticky error
        do_reset();
        repeat (MT + 1) cycle(stall);
        @(negedge clock);
        check("timeout state", 32'(ctrlState), 32'd3);
        check("timeout err", 32'(errTimeout), 32'd1);
        repeat (2) cycle(ready);
        mid_reset("halt");

        // halt drain
        do_reset();
        cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1));
        repeat (DC) cycle(idle);
        @(negedge clock);
        check("drain to HALT", 32'(ctrlState), 32'd3);
        check("drain halted", 32'(halted), 32'd1);

        // memory stall during drain freezes the drain count
        do_reset();
        cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1));
        cycle(idle);
        repeat (2) cycle(stall);
        repeat (3) cycle(idle);

        // reset in MEM_WAIT and in DRAIN
        do_reset();
        repeat (2) cycle(stall);
        mid_reset("memwait");
        do_reset();
        cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1));
        cycle(idle);
        mid_reset("drain");

        // randomized traffic against the model
        for (int s = 0; s < 12; s++) begin
            do_reset();
            bias = int'($urandom_range(1, 3));
            for (int c = 0; c < 250; c++) cycle(rand_in(bias));
        end
        @(negedge clock);
        check_state();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
